// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the data-memory port: key-event FIFO, game tick timer, RAM pass-through.
// Define MMIO_LED_EN to add the read/write LED register at offset 0x04.
module dmem_mmio_responder #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          TICK_DIV   = 1000000,
    parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic        rden,
    output logic [31:0] q_dmem,
    input  logic [31:0] q_ram,
    output logic        wren_ram,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        key_ready,
    output logic [15:0] led
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic             sel;
    logic [7:0]       off;
    logic             wr_sel;
    logic [7:0]       key_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       count8;
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      tick_cnt_q, tick_cnt_d;
    logic             flag_q, flag_d;
    logic             empty, full, pop, push, tick;
    logic [31:0]      mmio_rdata;

    assign sel    = (address_dmem[11:8] == MMIO_BASE[11:8]);
    assign off    = address_dmem[7:0];
    assign wr_sel = wren & sel;
    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_C);
    assign count8 = 8'(count_q);
    assign pop    = rden & sel & (off == 8'h00) & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push   = key_valid & (~full | pop);
    assign tick   = (div_q == DIV_LAST);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_cnt_d = tick ? tick_cnt_q + 32'd1 : tick_cnt_q;
        flag_d     = flag_q;
        if (pop)
            head_d = head_q + 1'b1;
        if (push)
            tail_d = tail_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        if (wr_sel && off == 8'h01)
            ovf_d = 1'b0;
        if (key_valid && !push)
            ovf_d = 1'b1;
        if (wr_sel && off == 8'h02)
            tick_cnt_d = data;
        if (wr_sel && off == 8'h03 && data[0])
            flag_d = 1'b0;
        if (tick)
            flag_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            div_q      <= '0;
            tick_cnt_q <= '0;
            flag_q     <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            flag_q     <= flag_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clock) begin
        if (push)
            key_mem[tail_q] <= key_code;
    end

`ifdef MMIO_LED_EN
    logic [15:0] led_q, led_d;

    always_comb begin
        led_d = led_q;
        if (wr_sel && off == 8'h04)
            led_d = data[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            led_q <= '0;
        else
            led_q <= led_d;
    end

    assign led = led_q;
`else
    assign led = 16'h0000;
`endif

    always_comb begin
        mmio_rdata = '0;
        case (off)
            8'h00: if (!empty) mmio_rdata = {23'b0, 1'b1, key_mem[head_q]};
            8'h01: mmio_rdata = {16'b0, count8, 5'b0, ovf_q, full, empty};
            8'h02: mmio_rdata = tick_cnt_q;
            8'h03: mmio_rdata = {31'b0, flag_q};
`ifdef MMIO_LED_EN
            8'h04: mmio_rdata = {16'b0, led_q};
`endif
            default: mmio_rdata = '0;
        endcase
    end

    assign q_dmem    = sel ? mmio_rdata : q_ram;
    assign wren_ram  = wren & ~sel;
    assign key_ready = ~full;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized scoreboard bench for dmem_mmio_responder against a queue-based reference model.
// Honours MMIO_LED_EN the same way the design does.
module tb_dmem_mmio_responder;

    localparam int DEPTH = 8;
    localparam int TDIV  = 4;

    logic        clock;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        rden;
    logic [31:0] q_dmem;
    logic [31:0] q_ram;
    logic        wren_ram;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ready;
    logic [15:0] led;

    dmem_mmio_responder #(
        .FIFO_DEPTH(DEPTH),
        .TICK_DIV  (TDIV),
        .MMIO_BASE (12'hF00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .rden        (rden),
        .q_dmem      (q_dmem),
        .q_ram       (q_ram),
        .wren_ram    (wren_ram),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .led         (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the dmem syncram, driven only by what the DUT emits.
    logic [31:0] ram_p [4096];
    assign q_ram = ram_p[address_dmem];
    always @(posedge clock) begin
        if (wren_ram)
            ram_p[address_dmem] <= data;
    end

    typedef struct {
        logic [31:0] q;
        logic        wr;
        logic        rdy;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  fifo_m[$];
    bit          ovf_m;
    bit          flag_m;
    logic [31:0] tcnt_m;
    int unsigned cyc_m;
    logic [15:0] led_m;
    logic [31:0] ram_m [4096];

    function automatic void model_reset();
        fifo_m.delete();
        ovf_m  = 1'b0;
        flag_m = 1'b0;
        tcnt_m = '0;
        cyc_m  = 0;
        led_m  = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int n;
        n = fifo_m.size();
        if (a[11:8] != 4'hF)
            return ram_m[a];
        case (a[7:0])
            8'h00: return (n == 0) ? 32'h0 : {23'b0, 1'b1, fifo_m[0]};
            8'h01: return {16'b0, 8'(n), 5'b0, ovf_m, (n == DEPTH), (n == 0)};
            8'h02: return tcnt_m;
            8'h03: return {31'b0, flag_m};
`ifdef MMIO_LED_EN
            8'h04: return {16'b0, led_m};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step(input bit rd, input bit wr, input logic [11:0] a,
                                       input logic [31:0] d, input bit kv, input logic [7:0] kc);
        bit s, pop, push, tick;
        int n;
        s    = (a[11:8] == 4'hF);
        n    = fifo_m.size();
        pop  = rd && s && (a[7:0] == 8'h00) && (n > 0);
        push = kv && ((n < DEPTH) || pop);
        tick = ((cyc_m % TDIV) == TDIV - 1);
        if (pop)
            void'(fifo_m.pop_front());
        if (push)
            fifo_m.push_back(kc);
        if (wr && s && a[7:0] == 8'h01)
            ovf_m = 1'b0;
        if (kv && !push)
            ovf_m = 1'b1;
        if (tick)
            tcnt_m = tcnt_m + 32'd1;
        if (wr && s && a[7:0] == 8'h02)
            tcnt_m = d;
        if (wr && s && a[7:0] == 8'h03 && d[0])
            flag_m = 1'b0;
        if (tick)
            flag_m = 1'b1;
`ifdef MMIO_LED_EN
        if (wr && s && a[7:0] == 8'h04)
            led_m = d[15:0];
`endif
        if (wr && !s)
            ram_m[a] = d;
        cyc_m++;
    endfunction

    task automatic applyStimulus(input bit rd, input bit wr, input logic [11:0] a,
                                 input logic [31:0] d, input bit kv, input logic [7:0] kc);
        exp_t e;
        rden         = rd;
        wren         = wr;
        address_dmem = a;
        data         = d;
        key_valid    = kv;
        key_code     = kc;
        e.q   = model_read(a);
        e.wr  = wr && (a[11:8] != 4'hF);
        e.rdy = (fifo_m.size() < DEPTH);
        e.led = led_m;
        exp_q.push_back(e);
        @(posedge clock);
        if (!reset)
            model_step(rd, wr, a, d, kv, kc);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (q_dmem !== e.q) begin
            bad++;
            $display("[TB] FAIL q_dmem t=%0t addr=%h actual=%h required=%h", $time, address_dmem, q_dmem, e.q);
        end
        total++;
        if (wren_ram !== e.wr) begin
            bad++;
            $display("[TB] FAIL wren_ram t=%0t actual=%b required=%b", $time, wren_ram, e.wr);
        end
        total++;
        if (key_ready !== e.rdy) begin
            bad++;
            $display("[TB] FAIL key_ready t=%0t actual=%b required=%b", $time, key_ready, e.rdy);
        end
        total++;
        if (led !== e.led) begin
            bad++;
            $display("[TB] FAIL led t=%0t actual=%h required=%h", $time, led, e.led);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0)
                checkOutput(exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic push_code(input logic [7:0] kc);
        applyStimulus(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, kc);
    endtask

    task automatic lw(input logic [11:0] a);
        applyStimulus(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic sw(input logic [11:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, a, d, 1'b0, 8'h00);
    endtask

    // Reset lands between edges; the check at the following negedge sees no rising edge.
    task automatic reset_mid();
        exp_t e;
        rden         = 1'b1;
        wren         = 1'b0;
        address_dmem = 12'hF01;
        key_valid    = 1'b0;
        reset        = 1'b1;
        model_reset();
        e.q   = 32'h0000_0001;
        e.wr  = 1'b0;
        e.rdy = 1'b1;
        e.led = 16'h0000;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        lw(12'hF02);
        reset = 1'b0;
    endtask

    initial begin
        int          guard;
        int          op;
        logic [11:0] a;
        logic [7:0]  o;
        bit          kv;
        for (int i = 0; i < 4096; i++) begin
            ram_p[i] = '0;
            ram_m[i] = '0;
        end
        reset        = 1'b1;
        rden         = 1'b0;
        wren         = 1'b0;
        address_dmem = '0;
        data         = '0;
        key_valid    = 1'b0;
        key_code     = '0;
        model_reset();
        @(posedge clock);
        #1;
        lw(12'hF00);
        lw(12'hF01);
        reset = 1'b0;

        idle(12);
        lw(12'hF02);
        lw(12'hF03);
        sw(12'hF03, 32'h1);
        lw(12'hF03);
        for (int i = 0; i < TDIV; i++)
            sw(12'hF02, 32'h0000_000A);
        lw(12'hF02);

        push_code(8'h1C);
        push_code(8'h1D);
        push_code(8'h1B);
        for (int i = 0; i < 4; i++)
            lw(12'hF00);
        lw(12'hF01);

        for (int i = 0; i < 9; i++)
            push_code(8'h40 + 8'(i));
        lw(12'hF01);
        sw(12'hF01, 32'h0);
        lw(12'hF01);
        applyStimulus(1'b1, 1'b0, 12'hF00, 32'h0, 1'b1, 8'h77);
        lw(12'hF01);
        for (int i = 0; i < DEPTH; i++)
            lw(12'hF00);
        lw(12'hF00);

        sw(12'h005, 32'h0000_DEAD);
        lw(12'h005);
        sw(12'hF02, 32'h1234_5678);
        lw(12'h005);
        sw(12'hF04, 32'h0000_BEEF);
        lw(12'hF04);
        sw(12'hF80, 32'hFFFF_FFFF);
        lw(12'hF80);

        push_code(8'h21);
        push_code(8'h22);
        push_code(8'h23);
        idle(3);
        reset_mid();
        lw(12'hF01);

        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 5);
            kv = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            o  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            if (op <= 3)
                a = {4'hF, o};
            else
                a = {4'($urandom_range(0, 14)), 6'b0, 2'($urandom_range(0, 3))};
            case (op)
                0:       applyStimulus(1'b0, 1'b0, a, $urandom, kv, 8'($urandom));
                1, 2, 4: applyStimulus(1'b1, 1'b0, a, $urandom, kv, 8'($urandom));
                default: applyStimulus(1'b0, 1'b1, a, $urandom, kv, 8'($urandom));
            endcase
        end
        idle(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory port, placed between the processor and the dmem syncram.
- Decodes the top of the 12-bit word address space into peripheral registers: a key-event FIFO fed by the keyboard decoder, and a game tick timer.
- All other addresses pass through to RAM.
- Adds zero latency: read data is combinational, so it meets the same-cycle timing as the negedge-clocked dmem. Side effects commit on the rising edge of clock.

Parameters:
- FIFO_DEPTH, 8, key FIFO entries; power of 2, range 2..128.
- TICK_DIV, 1000000, clock cycles per game tick; must be >= 2.
- MMIO_BASE, 12'hF00, base word address. MMIO is selected when address_dmem[11:8] == MMIO_BASE[11:8].

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- address_dmem  in  12  word address from the processor.
- data  in  32  store data from the processor.
- wren  in  1  store strobe from the processor.
- rden  in  1  load strobe: the processor is executing lw this cycle.
- q_dmem  out  32  load data to the processor.
- q_ram  in  32  read data from the dmem syncram.
- wren_ram  out  1  write enable to the dmem syncram, equal to wren & ~sel.
- key_valid  in  1  keyboard decoder push request.
- key_code  in  8  scan code accompanying the push.
- key_ready  out  1  FIFO not full.
- led  out  16  LED register (see Optional Feature).

Behaviour:
- sel = MMIO decode as defined under MMIO_BASE; off = address_dmem[7:0].
- q_dmem = sel ? mmio_rdata : q_ram. This path is purely combinational.
- Register map (offset: read / write):
  - 0x00 KEY_DATA: read {23'b0, !empty, head_code}, returns 0 when empty. Write is ignored.
  - 0x01 KEY_STATUS: read {count[15:8], 5'b0, overflow, full, empty}. Any write clears overflow.
  - 0x02 TICK_COUNT: read the 32-bit tick counter. Write loads data.
  - 0x03 TICK_FLAG: read {31'b0, flag}. Write with data[0]=1 clears flag.
  - Any other offset: read 0, write ignored.
- Pop: occurs when rden & sel & off==0 & !empty. The head advances at the next rising edge. Popping when empty has no effect.
- Push: occurs when key_valid & (!full | pop).
  - Simultaneous push and pop at full is allowed; count is unchanged.
  - Push when full without pop drops the code and sets the sticky overflow bit.
  - Overflow set and clear in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- key_ready = !full, registered state only (no combinational path from rden).
- Divider:
  - div counts 0..TICK_DIV-1. When div==TICK_DIV-1, div returns to 0, TICK_COUNT increments (wrapping 2^32→0) and flag is set.
  - A store to TICK_COUNT in the same cycle as an increment: the store wins.
  - A clear of flag in the same cycle as a tick: set wins.
  - Storing to TICK_COUNT does not reset div.
- wren_ram = wren & ~sel. MMIO stores never reach RAM. RAM behaviour is unchanged for non-MMIO addresses.
- Reset (asynchronous, any time, including mid-access):
  - FIFO empty, overflow=0, div=0, TICK_COUNT=0, flag=0, led=0.
  - key_ready=1.
  - q_dmem reflects the reset state immediately, e.g. a KEY_DATA read returns 0.
- rden and wren both high is illegal; the behaviour is unspecified and the bench never drives it.

Optional Feature:
- Macro MMIO_LED_EN.
- Defined: offset 0x04 LED is read/write; a write loads data[15:0] into led; a read returns {16'b0, led}.
- Undefined: offset 0x04 behaves as unmapped (read 0, write ignored), and led is tied to 16'h0000.

Test Plan:
- Push 0x1C, 0x1D, 0x1B, then three lw to 0xF00 followed by a fourth lw → reads 0x11C, 0x11D, 0x11B, then 0x000. KEY_STATUS then reads 0x00000001.
- Push 9 codes with FIFO_DEPTH=8 → after the 8th push key_ready=0. The 9th code is dropped. KEY_STATUS=0x00000806. A sw to 0xF01 → KEY_STATUS=0x00000802.
- With FIFO full, assert key_valid in the same cycle as a KEY_DATA pop → count stays 8, overflow stays 0, and the new code is at the tail.
- With TICK_DIV=4, run 12 cycles from reset → TICK_COUNT=3, flag=1. sw 0x1 to 0xF03 → flag=0. sw 0x0000000A to 0xF02 on a tick cycle → TICK_COUNT=0x0A.
- sw 0xDEAD to 0x005 → wren_ram=1, and a later lw 0x005 returns 0xDEAD from RAM. sw to 0xF02 → wren_ram=0 and the RAM contents are unchanged.
- Assert reset mid-sequence with FIFO count=3 and flag=1 → key_ready=1 and KEY_STATUS=0x1 immediately, with no rising edge required; TICK_COUNT=0 and led=0.
